// File: rtl/ram_ctrl_pkg.sv
// Shared types and sizing for the burst RAM controller.
package ram_ctrl_pkg;

    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefAddrWidth = 4;
    localparam int unsigned DefLenWidth  = 4;

    function automatic int unsigned depth_of(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StRead  = 2'd2,
        StDrain = 2'd3
    } state_e;

endpackage

// File: rtl/ram_ctrl_addr_gen.sv
// Loadable wrap-around address counter with a down-counting beat counter.
module ram_ctrl_addr_gen
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned LEN_WIDTH  = DefLenWidth
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  advance,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [LEN_WIDTH-1:0]  load_len,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    localparam int unsigned Depth = depth_of(ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  beats_q, beats_d;

    always_comb begin
        addr_d  = addr_q;
        beats_d = beats_q;
        if (load) begin
            addr_d  = load_addr;
            beats_d = load_len;
        end else if (advance) begin
            addr_d = (addr_q == ADDR_WIDTH'(Depth - 1)) ? '0 : addr_q + 1'b1;
            // Saturate so the final advance of a read leaves last asserted.
            if (beats_q != '0) begin
                beats_d = beats_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            beats_q <= '0;
        end else begin
            addr_q  <= addr_d;
            beats_q <= beats_d;
        end
    end

    assign addr = addr_q;
    assign last = (beats_q == '0);

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst read/write initiator for the single-port synchronous RAM.
// All outputs are registered; reads return one beat per cycle after a 2-cycle fill.
module ram_burst_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned LEN_WIDTH  = DefLenWidth
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wr_done,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_last,
    output logic                  ram_cs,
    output logic                  ram_wr_en,
    output logic                  ram_out_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    state_e state_q, state_d;

    logic                  first_q, first_d;
    logic                  drain_pin_q, drain_pin_d;
    logic                  req_ready_q, req_ready_d;
    logic                  wdata_ready_q, wdata_ready_d;
    logic                  wr_done_q, wr_done_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_last_q, rsp_last_d;
    logic                  ram_cs_q, ram_cs_d;
    logic                  ram_wr_en_q, ram_wr_en_d;
    logic                  ram_out_en_q, ram_out_en_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_data_in_q, ram_data_in_d;

    logic                  ag_load;
    logic                  ag_advance;
    logic [ADDR_WIDTH-1:0] ag_addr;
    logic                  ag_last;

    ram_ctrl_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (ag_load),
        .advance  (ag_advance),
        .load_addr(req_addr),
        .load_len (req_len),
        .addr     (ag_addr),
        .last     (ag_last)
    );

    always_comb begin
        state_d       = state_q;
        first_d       = first_q;
        ag_load       = 1'b0;
        ag_advance    = 1'b0;
        ram_cs_d      = 1'b0;
        ram_wr_en_d   = 1'b0;
        ram_out_en_d  = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_data_in_d = ram_data_in_q;
        wr_done_d     = 1'b0;
        drain_pin_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (req_valid && req_ready_q) begin
                    ag_load = 1'b1;
                    first_d = 1'b1;
                    state_d = req_write ? StWrite : StRead;
                end
            end
            StWrite: begin
                if (wdata_valid && wdata_ready_q) begin
                    ram_cs_d      = 1'b1;
                    ram_wr_en_d   = 1'b1;
                    ram_addr_d    = ag_addr;
                    ram_data_in_d = wdata;
                    ag_advance    = 1'b1;
                    if (ag_last) begin
                        wr_done_d = 1'b1;
                        state_d   = StIdle;
                    end
                end
            end
            StRead: begin
                ram_cs_d     = 1'b1;
                ram_addr_d   = ag_addr;
                // The RAM has nothing to drive until the first address has been clocked in.
                ram_out_en_d = ~first_q;
                first_d      = 1'b0;
                ag_advance   = 1'b1;
                if (ag_last) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                ram_cs_d     = 1'b1;
                ram_out_en_d = 1'b1;
                drain_pin_d  = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase

        req_ready_d   = (state_d == StIdle);
        wdata_ready_d = (state_d == StWrite);

        // The drain pin cycle carries the last address's data back.
        rsp_valid_d = ram_out_en_q;
        rsp_last_d  = ram_out_en_q & drain_pin_q;
        rsp_rdata_d = ram_out_en_q ? ram_rdata : rsp_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            first_q       <= 1'b0;
            drain_pin_q   <= 1'b0;
            req_ready_q   <= 1'b0;
            wdata_ready_q <= 1'b0;
            wr_done_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_last_q    <= 1'b0;
            ram_cs_q      <= 1'b0;
            ram_wr_en_q   <= 1'b0;
            ram_out_en_q  <= 1'b0;
            ram_addr_q    <= '0;
            ram_data_in_q <= '0;
        end else begin
            state_q       <= state_d;
            first_q       <= first_d;
            drain_pin_q   <= drain_pin_d;
            req_ready_q   <= req_ready_d;
            wdata_ready_q <= wdata_ready_d;
            wr_done_q     <= wr_done_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_last_q    <= rsp_last_d;
            ram_cs_q      <= ram_cs_d;
            ram_wr_en_q   <= ram_wr_en_d;
            ram_out_en_q  <= ram_out_en_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_in_q <= ram_data_in_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign wdata_ready = wdata_ready_q;
    assign wr_done     = wr_done_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_last    = rsp_last_q;
    assign ram_cs      = ram_cs_q;
    assign ram_wr_en   = ram_wr_en_q;
    assign ram_out_en  = ram_out_en_q;
    assign ram_addr    = ram_addr_q;
    assign ram_data_in = ram_data_in_q;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Scoreboard bench for ram_burst_ctrl with a behavioural RAM and reference memory.
module tb_ram_burst_ctrl;
    import ram_ctrl_pkg::*;

    localparam int unsigned Depth = depth_of(4);

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        logic       wr;
        logic       oe;
        logic       done;
        int         cyc;
    } pin_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         cyc;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_write;
    logic [3:0] req_addr, req_len;
    logic       wdata_valid, wdata_ready;
    logic [7:0] wdata;
    logic       wr_done, rsp_valid, rsp_last;
    logic [7:0] rsp_rdata;
    logic       ram_cs, ram_wr_en, ram_out_en;
    logic [3:0] ram_addr;
    logic [7:0] ram_data_in, ram_rdata;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural synchronous RAM: address captured on the edge, data driven while out_en.
    logic [7:0] ram_mem [Depth];
    logic [7:0] ram_rd_q;
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_wr_en) ram_mem[ram_addr] <= ram_data_in;
            else           ram_rd_q <= ram_mem[ram_addr];
        end
    end
    assign ram_rdata = ram_out_en ? ram_rd_q : 8'hEE;

    ram_burst_ctrl #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .LEN_WIDTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .wdata_valid(wdata_valid),
        .wdata_ready(wdata_ready),
        .wdata      (wdata),
        .wr_done    (wr_done),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_last   (rsp_last),
        .ram_cs     (ram_cs),
        .ram_wr_en  (ram_wr_en),
        .ram_out_en (ram_out_en),
        .ram_addr   (ram_addr),
        .ram_data_in(ram_data_in),
        .ram_rdata  (ram_rdata)
    );

    int         total = 0;
    int         bad = 0;
    pin_t       pin_q [$];
    rsp_t       rsp_q [$];
    logic [7:0] ref_mem [Depth];
    logic [7:0] wbuf [16];
    int         cs_seen = 0;
    int         oe_seen = 0;
    int         rv_seen = 0;
    int         wd_seen = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic monitor();
        pin_t       p;
        rsp_t       r;
        logic [7:0] prev_rdata = 8'h00;
        logic       prev_rst = 1'b1;
        forever begin
            @(negedge clk);
            if (ram_cs) begin
                cs_seen++;
                if (ram_out_en) oe_seen++;
                if (pin_q.size() == 0) begin
                    chk("pin_unexpected_cs", 32'(ram_addr), 32'hFFFF_FFFF);
                end else begin
                    p = pin_q.pop_front();
                    chk("pin_addr", 32'(ram_addr), 32'(p.addr));
                    chk("pin_wr_en", 32'(ram_wr_en), 32'(p.wr));
                    chk("pin_out_en", 32'(ram_out_en), 32'(p.oe));
                    chk("pin_wr_done", 32'(wr_done), 32'(p.done));
                    chk("pin_cycle", 32'(cyc), 32'(p.cyc));
                    if (p.wr) chk("pin_wdata", 32'(ram_data_in), 32'(p.data));
                end
            end else begin
                chk("idle_pins", 32'({wr_done, ram_wr_en, ram_out_en}), 32'd0);
            end
            if (wr_done) wd_seen++;
            if (rsp_valid) begin
                rv_seen++;
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_rdata), 32'hFFFF_FFFF);
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp_data", 32'(rsp_rdata), 32'(r.data));
                    chk("rsp_last", 32'(rsp_last), 32'(r.last));
                    chk("rsp_cycle", 32'(cyc), 32'(r.cyc));
                end
            end else begin
                chk("rsp_last_idle", 32'(rsp_last), 32'd0);
                if (!prev_rst) chk("rdata_hold", 32'(rsp_rdata), 32'(prev_rdata));
            end
            chk("inv_oe_and_we", 32'(ram_out_en & ram_wr_en), 32'd0);
            chk("inv_oe_without_cs", 32'(ram_out_en & ~ram_cs), 32'd0);
            prev_rdata = rsp_rdata;
            prev_rst   = rst;
        end
    endtask

    task automatic send_req(input logic w, input logic [3:0] a, input logic [3:0] l,
                            output int acc);
        int t = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_len   = l;
        @(negedge clk);
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        acc       = cyc;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 4'($urandom);
        req_len   = 4'($urandom);
    endtask

    task automatic do_write(input logic [3:0] a, input int n, input int stall_at,
                            input int stall_len);
        int   acc;
        int   t;
        pin_t p;
        send_req(1'b1, a, 4'(n - 1), acc);
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    wdata_valid = 1'b0;
                    wdata       = 8'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            wdata_valid = 1'b1;
            wdata       = wbuf[i];
            t = 0;
            @(negedge clk);
            while (!wdata_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!wdata_ready) chk("wdata_ready_timeout", 32'(wdata_ready), 32'd1);
            @(posedge clk);
            #1;
            p.addr = 4'(a + 4'(i));
            p.data = wbuf[i];
            p.wr   = 1'b1;
            p.oe   = 1'b0;
            p.done = (i == n - 1);
            p.cyc  = cyc;
            pin_q.push_back(p);
            ref_mem[p.addr] = wbuf[i];
        end
        wdata_valid = 1'b0;
    endtask

    // Read pins: N issue cycles then one drain at the last address; beats 3 cycles after accept.
    task automatic do_read(input logic [3:0] a, input int n, output int acc);
        pin_t p;
        rsp_t r;
        send_req(1'b0, a, 4'(n - 1), acc);
        for (int i = 0; i < n; i++) begin
            p.addr = 4'(a + 4'(i));
            p.data = 8'h00;
            p.wr   = 1'b0;
            p.oe   = (i != 0);
            p.done = 1'b0;
            p.cyc  = acc + 1 + i;
            pin_q.push_back(p);
            r.data = ref_mem[p.addr];
            r.last = (i == n - 1);
            r.cyc  = acc + 3 + i;
            rsp_q.push_back(r);
        end
        p.addr = 4'(a + 4'(n - 1));
        p.oe   = 1'b1;
        p.cyc  = acc + n + 1;
        pin_q.push_back(p);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((pin_q.size() != 0 || rsp_q.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("drain_timeout", 32'(pin_q.size() + rsp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int w0;
        int cs0;
        int oe0;
        int rv0;
        int t0;
        int n;
        #600000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int w0;
        int cs0;
        int oe0;
        int rv0;
        int t0;
        int n;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = 4'd0;
        req_len     = 4'd0;
        wdata_valid = 1'b0;
        wdata       = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({req_ready, wdata_ready, wr_done, rsp_valid, rsp_rdata, rsp_last,
                                  ram_cs, ram_wr_en, ram_out_en, ram_addr, ram_data_in}), 32'd0);
        fork
            monitor();
        join_none
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("req_ready_after_reset", 32'(req_ready), 32'd1);
        chk("wdata_ready_in_idle", 32'(wdata_ready), 32'd0);

        // Single beat write then read back.
        w0 = wd_seen;
        wbuf[0] = 8'hA5;
        do_write(4'd3, 1, -1, 0);
        wait_idle();
        chk("wr_done_pulses_1beat", 32'(wd_seen - w0), 32'd1);
        do_read(4'd3, 1, acc);
        wait_idle();

        // Four beats wrapping past the top of the address space.
        w0 = wd_seen;
        for (int i = 0; i < 4; i++) wbuf[i] = 8'(8'h10 + i);
        do_write(4'd14, 4, -1, 0);
        wait_idle();
        chk("wr_done_pulses_4beat", 32'(wd_seen - w0), 32'd1);
        do_read(4'd14, 4, acc);
        wait_idle();

        // Two-cycle wdata stall ahead of the second beat.
        for (int i = 0; i < 3; i++) wbuf[i] = 8'($urandom);
        do_write(4'd5, 3, 1, 2);
        wait_idle();
        do_read(4'd5, 3, acc);
        wait_idle();

        // Fill the whole RAM, then a full-depth read.
        for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
        do_write(4'd0, 16, 7, 1);
        wait_idle();
        cs0 = cs_seen;
        oe0 = oe_seen;
        rv0 = rv_seen;
        do_read(4'd0, 16, acc);
        wait_idle();
        chk("full_read_cs_cycles", 32'(cs_seen - cs0), 32'd17);
        chk("full_read_oe_cycles", 32'(oe_seen - oe0), 32'd16);
        chk("full_read_rsp_beats", 32'(rv_seen - rv0), 32'd16);

        // Reset during beat 2 of a 4-beat read.
        rv0 = rv_seen;
        do_read(4'd9, 4, acc);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        pin_q.delete();
        rsp_q.delete();
        chk("midburst_reset_outputs",
            32'({req_ready, wdata_ready, wr_done, rsp_valid, rsp_rdata, rsp_last,
                 ram_cs, ram_wr_en, ram_out_en, ram_addr, ram_data_in}), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("req_ready_after_midburst_reset", 32'(req_ready), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("rsp_beats_before_reset", 32'(rv_seen - rv0), 32'd2);

        // Random traffic; stray wdata_valid during idle/read must be ignored.
        t0 = cyc;
        while (cyc < t0 + 1000) begin
            if ($urandom_range(1, 0) == 1) begin
                n = int'($urandom_range(8, 1));
                for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
                do_write(4'($urandom), n, int'($urandom_range(n - 1, 0)),
                         int'($urandom_range(2, 0)));
            end else begin
                do_read(4'($urandom), int'($urandom_range(16, 1)), acc);
            end
            wait_idle();
            wdata_valid = 1'($urandom);
            wdata       = 8'($urandom);
            repeat ($urandom_range(2, 0)) begin
                @(posedge clk);
                #1;
            end
        end
        wdata_valid = 1'b0;
        wait_idle();
        repeat (4) @(posedge clk);
        #1;
        chk("queues_empty_at_end", 32'(pin_q.size() + rsp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
- Initiator/master for the team's single-port synchronous RAM.
- Accepts burst read/write requests on a valid/ready request port.
- Drives the RAM chip-select, write-enable, output-enable, address and write-data pins.
- Returns read data as a response stream. Reads are pipelined: one beat per cycle after a 2-cycle fill.

Parameters:
- DATA_WIDTH, 8, RAM word width
- ADDR_WIDTH, 4, RAM address width; DEPTH = 2**ADDR_WIDTH
- LEN_WIDTH, 4, burst length field width; beats = req_len+1

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request
- req_write  input  1  1 = write burst, 0 = read burst
- req_addr  input  ADDR_WIDTH  start address
- req_len  input  LEN_WIDTH  beats minus one
- wdata_valid  input  1  write beat present
- wdata_ready  output  1  write beat accepted
- wdata  input  DATA_WIDTH  write beat data
- wr_done  output  1  one-cycle pulse on final write pin cycle
- rsp_valid  output  1  read beat valid; no backpressure
- rsp_rdata  output  DATA_WIDTH  read beat data
- rsp_last  output  1  final read beat
- ram_cs  output  1  RAM chip select
- ram_wr_en  output  1  RAM write enable
- ram_out_en  output  1  RAM output enable
- ram_addr  output  ADDR_WIDTH  RAM address
- ram_data_in  output  DATA_WIDTH  RAM write data
- ram_rdata  input  DATA_WIDTH  RAM read bus; high-Z when not driven

Behaviour:
- Reset: all outputs are registered and clear to 0, including req_ready and wdata_ready. State returns to IDLE.
- Reset mid-burst: the burst is abandoned. No further rsp_valid or wr_done is produced. RAM contents already written stay written.
- States are IDLE, WRITE, READ and DRAIN.
- req_ready is 1 only in IDLE. A request is accepted on the edge where req_valid && req_ready. A beat counter loads req_len and an address counter loads req_addr.
- Address counter increments modulo DEPTH. Example: 14, len 3 gives addresses 14, 15, 0, 1.
- WRITE state:
  - wdata_ready = 1.
  - Each accepted beat registers ram_cs=1, ram_wr_en=1, ram_addr=cur, ram_data_in=wdata on the next cycle.
  - If no beat is accepted, next cycle ram_cs=0 and ram_wr_en=0 (stall; address does not advance).
  - After the last beat is accepted, go to IDLE. wr_done pulses in the same cycle the last write appears on the pins.
- READ state:
  - Each cycle drives ram_cs=1, ram_wr_en=0, ram_addr=cur; the address advances every cycle.
  - ram_out_en=1 from the second issue cycle onward.
  - After issuing the last address, go to DRAIN.
- DRAIN state (one cycle): ram_cs=1, ram_wr_en=0, ram_out_en=1, ram_addr held at the last address. The redundant re-read is harmless. Then go to IDLE.
- Read timing:
  - ram_rdata is sampled only at edges where ram_out_en=1.
  - The sample is registered to rsp_rdata, with rsp_valid=1 the following cycle.
  - For an N-beat read accepted at edge E0: ram_cs is high for N+1 cycles and ram_out_en for N cycles. rsp_valid is high in cycles 3..N+2 after E0, contiguous. rsp_last is on the final beat.
- Invariants:
  - ram_out_en and ram_wr_en are never both 1.
  - ram_out_en=1 implies ram_cs=1.
  - rsp_rdata holds its value when rsp_valid=0.
- Back-to-back: IDLE always lasts at least one cycle between bursts.
- A write followed by a read of the same address returns the new data, because the last write reaches the RAM pins before the read is issued.
- wdata_valid is ignored outside WRITE. req_* is ignored outside IDLE.

Decomposition:
- ram_ctrl_pkg holds:
  - the state enum (IDLE/WRITE/READ/DRAIN)
  - default widths
  - DEPTH derivation
- One sub-module: ram_ctrl_addr_gen.
  - Function: loadable wrap-around address counter plus down-counting beat counter, with a last_beat flag.
  - Ports: load, advance, addr, last.
- The FSM and pin registers stay in ram_burst_ctrl.

Test Plan:
- Write 1 beat 0xA5 to addr 3, then read 1 beat from addr 3 -> wr_done one pulse; single rsp_valid with rsp_rdata=0xA5, rsp_last=1, 3 cycles after read acceptance.
- Write 4 beats 0x10..0x13 starting at addr 14, then read 4 from 14 -> ram_addr sequence 14, 15, 0, 1; rsp_rdata 0x10..0x13 on 4 consecutive cycles, rsp_last on 0x13.
- Write burst of 3 with wdata_valid low for 2 cycles mid-burst -> ram_cs/ram_wr_en drop for exactly 2 cycles, no address skip; readback matches.
- 16-beat read from addr 0 (len 15) -> ram_cs high 17 cycles, ram_out_en high 16, rsp_valid high 16 contiguous.
- Assert rst during beat 2 of a 4-beat read -> all outputs 0 next cycle, no further rsp_valid; req_ready=1 the cycle after reset deasserts.
- Random requests over 1000 cycles with a RAM model -> scoreboard match, and ram_out_en && ram_wr_en is never observed.
